frame_stepper: RTL

Consumer side of the animation frame-limit lookup. It holds the active animation index and drives it into the combinational limit table. It receives the returned frame count and steps a frame counter from 0 to limit−1 at a programmable rate, wrapping at the end. It also handles animation switching, pause, and single-step, and feeds `ani_cur`/`frame` to the segment pattern ROM.

---
 rtl/frame_stepper.sv | 115 +++++++++++
 1 files changed

// File: rtl/frame_stepper.sv
// frame_stepper: keeps the active animation index and steps its frame counter.
// Frames run from 0 to limit-1 at a programmable rate and wrap at the end.
// Also handles pause, single-step and animation switching.
// ani_cur/frame drive the frame-limit lookup and the segment pattern ROM.
module frame_stepper #(
  parameter int unsigned BASE_DIV = 12_000_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [5:0] ani_sel,
  input  logic [5:0] limit,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic [5:0] ani_cur,
  output logic [5:0] frame,
  output logic       frame_stb,
  output logic       wrap,
  output logic       paused
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_PAUSE = 1'b1;

  // One extra bit so that BASE_DIV == 2**DIV_W still fits.
  localparam logic [DIV_W:0] BASE_W = (DIV_W+1)'(BASE_DIV);

  logic [0:0]       state;
  logic [DIV_W-1:0] count;
  logic             step_q;

  logic [DIV_W:0]   period;
  logic [DIV_W:0]   period_m1;
  logic             tick;
  logic             step_rise;
  logic             advance;
  logic [5:0]       eff_lim;
  logic [5:0]       lim_m1;

  // Prescaler period for the current speed, clamped to at least one cycle.
  // The >= compare makes a speed increase fire at once when the count is
  // already past the new terminal value.
  always_comb begin
    period    = BASE_W >> speed;
    period_m1 = (period == '0) ? '0 : period - 1'b1;
    tick      = (state == ST_RUN) && ({1'b0, count} >= period_m1);
    step_rise = step & ~step_q;
    advance   = ena & (((state == ST_RUN) & tick) | ((state == ST_PAUSE) & step_rise));
    eff_lim   = (limit == 6'd0) ? 6'd1 : limit;
    lim_m1    = eff_lim - 6'd1;
  end

  // Step edge detector history; keeps tracking even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Run/pause state: follows the pause level one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (ena) begin
      state <= pause ? ST_PAUSE : ST_RUN;
    end
  end

  // Prescaler: counts in RUN and is parked at 0 in PAUSE, so a resume
  // waits a full period before the first tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (state == ST_PAUSE || tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Advance handling: a pending switch wins, then end-of-animation wrap,
  // then a plain increment. Strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ani_cur   <= 6'd0;
      frame     <= 6'd0;
      frame_stb <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      wrap      <= 1'b0;
      if (advance) begin
        frame_stb <= 1'b1;
        if (ani_sel != ani_cur) begin
          ani_cur <= ani_sel;
          frame   <= 6'd0;
        end else if (frame >= lim_m1) begin
          frame <= 6'd0;
          wrap  <= 1'b1;
        end else begin
          frame <= frame + 6'd1;
        end
      end
    end
  end

  assign paused = (state == ST_PAUSE);

endmodule
